// File: rtl/lsu_align_pkg.sv
// rtl/lsu_align_pkg.sv - shared size codes, sequencer states and beat helpers for lsu_align_seq
package lsu_align_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of byte beats a misaligned access of this size needs
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      SZ_HALF: beat_count = 3'd2;
      SZ_WORD: beat_count = 3'd4;
      default: beat_count = 3'd1;
    endcase
  endfunction

  // Natural alignment check; illegal size reports aligned so only the size error applies
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: is_aligned = (addr_lo[0] == 1'b0);
      SZ_WORD: is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ld_extend.sv
// rtl/lsu_ld_extend.sv - sign/zero extension of an assembled load word by access size
module lsu_ld_extend
  import lsu_align_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ext_data
);

  // Replicate the top bit of the accessed width when sign extension is requested
  always_comb begin
    ext_data = asm_data;
    case (size)
      SZ_BYTE: ext_data = {{24{sign_ext & asm_data[7]}}, asm_data[7:0]};
      SZ_HALF: ext_data = {{16{sign_ext & asm_data[15]}}, asm_data[15:0]};
      default: ext_data = asm_data;
    endcase
  end

endmodule

// File: rtl/lsu_align_seq.sv
// rtl/lsu_align_seq.sv - load/store sequencer splitting misaligned accesses into byte beats (split enabled by LSU_ALIGN_SPLIT_EN)
module lsu_align_seq
  import lsu_align_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic        i_req_wren,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic [1:0]  o_lsu_size,
  output logic        o_lsu_signed,
  output logic        o_lsu_wren,
  input  logic [31:0] i_ld_data
);

  state_t      state;
  logic [1:0]  beat;
  logic [1:0]  last;
  logic        split;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_wren;
  logic [31:0] asm_data;
  logic [31:0] asm_next;
  logic [31:0] ext_data;
  logic [1:0]  cap_idx;
  logic        split_en;
  logic        accept;
  logic        req_aligned;
  logic        req_err;
  logic [2:0]  req_cnt;
  logic [1:0]  req_last;

`ifdef LSU_ALIGN_SPLIT_EN
  assign split_en = 1'b1;
`else
  assign split_en = 1'b0;
`endif

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign req_aligned = is_aligned(i_req_size, i_req_addr[1:0]);
  assign req_err     = (i_req_size == 2'b11) || (!req_aligned && !split_en);
  assign req_cnt     = beat_count(i_req_size);
  assign req_last    = 2'(req_cnt - 3'd1);

  // Byte returned this cycle belongs to the previous beat; in CAPT it is the final beat
  assign cap_idx = (state == CAPT) ? last : 2'(beat - 2'd1);

  // Drop the returning load byte into its slot of the assembly word
  always_comb begin
    asm_next = asm_data;
    case (cap_idx)
      2'd0: asm_next[7:0]   = i_ld_data[7:0];
      2'd1: asm_next[15:8]  = i_ld_data[7:0];
      2'd2: asm_next[23:16] = i_ld_data[7:0];
      default: asm_next[31:24] = i_ld_data[7:0];
    endcase
  end

  lsu_ld_extend u_ld_extend (
    .asm_data (asm_next),
    .size     (r_size),
    .sign_ext (r_signed),
    .ext_data (ext_data)
  );

  // Sequencer FSM with registered lsu drive and response outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      beat         <= 2'd0;
      last         <= 2'd0;
      split        <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_wren       <= 1'b0;
      asm_data     <= 32'd0;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= 32'd0;
      o_rsp_err    <= 1'b0;
      o_lsu_addr   <= 32'd0;
      o_st_data    <= 32'd0;
      o_lsu_size   <= SZ_BYTE;
      o_lsu_signed <= 1'b0;
      o_lsu_wren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_wren   <= i_req_wren;
            asm_data <= 32'd0;
            beat     <= 2'd0;
            if (req_err) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= 32'd0;
            end else begin
              state        <= ISSUE;
              split        <= !req_aligned;
              last         <= req_aligned ? 2'd0 : req_last;
              o_lsu_addr   <= i_req_addr;
              o_st_data    <= i_req_wdata;
              o_lsu_size   <= req_aligned ? i_req_size : SZ_BYTE;
              o_lsu_signed <= req_aligned ? i_req_signed : 1'b0;
              o_lsu_wren   <= i_req_wren;
            end
          end
        end
        ISSUE: begin
          if (split && (beat != 2'd0)) begin
            asm_data <= asm_next;
          end
          if (beat == last) begin
            o_lsu_wren <= 1'b0;
            if (r_wren) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= 32'd0;
              o_rsp_err   <= 1'b0;
            end else begin
              state <= CAPT;
            end
          end else begin
            beat       <= beat + 2'd1;
            o_lsu_addr <= o_lsu_addr + 32'd1;
            o_st_data  <= {8'h00, o_st_data[31:8]};
          end
        end
        CAPT: begin
          state       <= RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= split ? ext_data : i_ld_data;
        end
        default: begin
          state       <= IDLE;
          o_rsp_valid <= 1'b0;
          o_rsp_rdata <= 32'd0;
          o_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_seq.sv
// tb/tb_lsu_align_seq.sv - directed self-checking bench for lsu_align_seq with a byte-memory lsu model
module tb_lsu_align_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic        req_wren = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] lsu_addr;
  logic [31:0] st_data;
  logic [1:0]  lsu_size;
  logic        lsu_signed;
  logic        lsu_wren;
  logic [31:0] ld_data = 32'd0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [bit [31:0]];
  logic [31:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];
  logic [1:0]  wlog_size [$];

  lsu_align_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_size   (req_size),
    .i_req_signed (req_signed),
    .i_req_wren   (req_wren),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_lsu_addr   (lsu_addr),
    .o_st_data    (st_data),
    .o_lsu_size   (lsu_size),
    .o_lsu_signed (lsu_signed),
    .o_lsu_wren   (lsu_wren),
    .i_ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd8(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] w;
    w = {rd8(a + 32'd3), rd8(a + 32'd2), rd8(a + 32'd1), rd8(a)};
    case (sz)
      2'b00:   return {{24{sg & w[7]}}, w[7:0]};
      2'b01:   return {{16{sg & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // lsu model: writes commit at the edge, load data appears the cycle after the address
  always @(posedge clk) begin
    if (lsu_wren) begin
      mem[lsu_addr] = st_data[7:0];
      if (lsu_size != 2'b00) mem[lsu_addr + 32'd1] = st_data[15:8];
      if (lsu_size == 2'b10) begin
        mem[lsu_addr + 32'd2] = st_data[23:16];
        mem[lsu_addr + 32'd3] = st_data[31:24];
      end
      wlog_addr.push_back(lsu_addr);
      wlog_data.push_back(st_data[7:0]);
      wlog_size.push_back(lsu_size);
    end
    ld_data <= model_read(lsu_addr, lsu_size, lsu_signed);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: returns response cycle (0 = timeout), data, error and wren cycle count
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                     input logic sg, input logic wr, input int exp_cyc, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_wcnt);
    int cyc;
    int wcnt;
    logic [31:0] rd;
    logic er;
    cyc = 0; wcnt = 0; rd = 32'hxxxxxxxx; er = 1'bx;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    wlog_addr.delete(); wlog_data.delete(); wlog_size.delete();
    req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg; req_wren = wr; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_size = 2'b11; req_signed = ~sg; req_wren = ~wr;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lsu_wren) wcnt++;
      if (rsp_valid) begin
        cyc = c; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, "_wren_cycles"}, 32'(wcnt), 32'(exp_wcnt));
    @(negedge clk);
    chk({tag, "_pulse_end"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  // Accept a request, then assert reset during cycle 2 of its execution
  task automatic reset_mid(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic wr);
    @(negedge clk);
    req_addr = a; req_wdata = wd; req_size = sz; req_signed = 1'b0; req_wren = wr; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_wren_after"}, {31'd0, lsu_wren}, 32'd0);
    chk({tag, "_no_rsp_a"}, {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_no_rsp_b"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_no_rsp_c"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", lsu_addr, 32'd0);
    chk("rst_st_data", st_data, 32'd0);
    chk("rst_ctl", {29'd0, lsu_size, lsu_signed}, 32'd0);
    chk("rst_wren", {31'd0, lsu_wren}, 32'd0);

    // Aligned word store and load
    run("sw_10", 32'h10, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1, 2, 32'h0, 1'b0, 1);
    chk("sw_10_nwr", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() == 1) begin
      chk("sw_10_addr", wlog_addr[0], 32'h10);
      chk("sw_10_size", {30'd0, wlog_size[0]}, 32'd2);
    end
    chk("sw_10_mem", model_read(32'h10, 2'b10, 1'b0), 32'hCAFEF00D);
    run("lw_10", 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 3, 32'hCAFEF00D, 1'b0, 0);

    // Aligned half/byte with extension done by lsu
    run("sh_20", 32'h20, 32'h000080F0, 2'b01, 1'b0, 1'b1, 2, 32'h0, 1'b0, 1);
    run("lh_20", 32'h20, 32'h0, 2'b01, 1'b1, 1'b0, 3, 32'hFFFF80F0, 1'b0, 0);
    run("lhu_20", 32'h20, 32'h0, 2'b01, 1'b0, 1'b0, 3, 32'h000080F0, 1'b0, 0);
    run("lb_21", 32'h21, 32'h0, 2'b00, 1'b1, 1'b0, 3, 32'hFFFFFF80, 1'b0, 0);
    run("lbu_20", 32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 3, 32'h000000F0, 1'b0, 0);

    // Illegal size: immediate error, no lsu access
    run("ill_ld", 32'h40, 32'h0, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0);
    run("ill_st", 32'h40, 32'h12345678, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b1, 0);
    chk("ill_st_nwr", 32'(wlog_addr.size()), 32'd0);

`ifdef LSU_ALIGN_SPLIT_EN
    run("sw_65", 32'h65, 32'h11223344, 2'b10, 1'b0, 1'b1, 5, 32'h0, 1'b0, 4);
    chk("sw_65_nwr", 32'(wlog_addr.size()), 32'd4);
    if (wlog_addr.size() == 4) begin
      chk("sw_65_b0", {wlog_addr[0][23:0], wlog_data[0]}, 32'h00006544);
      chk("sw_65_b1", {wlog_addr[1][23:0], wlog_data[1]}, 32'h00006633);
      chk("sw_65_b2", {wlog_addr[2][23:0], wlog_data[2]}, 32'h00006722);
      chk("sw_65_b3", {wlog_addr[3][23:0], wlog_data[3]}, 32'h00006811);
      chk("sw_65_sz", {24'd0, wlog_size[0], wlog_size[1], wlog_size[2], wlog_size[3]}, 32'd0);
    end
    run("lw_65", 32'h65, 32'h0, 2'b10, 1'b0, 1'b0, 6, 32'h11223344, 1'b0, 0);

    run("sh_79", 32'h79, 32'h000080F0, 2'b01, 1'b0, 1'b1, 3, 32'h0, 1'b0, 2);
    run("lh_79", 32'h79, 32'h0, 2'b01, 1'b1, 1'b0, 4, 32'hFFFF80F0, 1'b0, 0);
    run("lhu_79", 32'h79, 32'h0, 2'b01, 1'b0, 1'b0, 4, 32'h000080F0, 1'b0, 0);
    run("lb_7a", 32'h7A, 32'h0, 2'b00, 1'b1, 1'b0, 3, 32'hFFFFFF80, 1'b0, 0);

    run("sh_wrap", 32'hFFFFFFFF, 32'h0000ABCD, 2'b01, 1'b0, 1'b1, 3, 32'h0, 1'b0, 2);
    chk("sh_wrap_hi", {24'd0, rd8(32'hFFFFFFFF)}, 32'hCD);
    chk("sh_wrap_lo", {24'd0, rd8(32'h0)}, 32'hAB);
    run("lhu_wrap", 32'hFFFFFFFF, 32'h0, 2'b01, 1'b0, 1'b0, 4, 32'h0000ABCD, 1'b0, 0);

    mem.delete();
    reset_mid("rst_sw65", 32'h65, 32'h11223344, 2'b10, 1'b1);
    chk("rst_mem65", {24'd0, rd8(32'h65)}, 32'h44);
    chk("rst_mem66", {24'd0, rd8(32'h66)}, 32'h33);
    chk("rst_mem67", {24'd0, rd8(32'h67)}, 32'h00);
    run("rst_lb65", 32'h65, 32'h0, 2'b00, 1'b0, 1'b0, 3, 32'h00000044, 1'b0, 0);
    run("rst_lb66", 32'h66, 32'h0, 2'b00, 1'b0, 1'b0, 3, 32'h00000033, 1'b0, 0);
`else
    run("sw_65_nosplit", 32'h65, 32'h11223344, 2'b10, 1'b0, 1'b1, 1, 32'h0, 1'b1, 0);
    chk("sw_65_nwr", 32'(wlog_addr.size()), 32'd0);
    run("lw_65_nosplit", 32'h65, 32'h0, 2'b10, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0);
    run("lh_21_nosplit", 32'h21, 32'h0, 2'b01, 1'b1, 1'b0, 1, 32'h0, 1'b1, 0);
    reset_mid("rst_lw10", 32'h10, 32'h0, 2'b10, 1'b0);
    run("lw_10_after", 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 3, 32'hCAFEF00D, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_align_seq.md
# lsu_align_seq

Request sequencer between the pipeline's memory stage and `lsu`, acting as the initiator on the `lsu` port set (`o_lsu_addr`, `o_st_data`, `o_lsu_size`, `o_lsu_signed`, `o_lsu_wren`, `i_ld_data`). It accepts one load/store request at a time with a valid/ready handshake. Aligned requests are issued as a single native-size access. Misaligned halfword/word requests are split into byte beats on consecutive cycles, and load bytes are merged and extended before a one-cycle response pulse.

## Interface
- No parameters; data/address width fixed at 32.
- `i_clk` in 1: sole clock, rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: high only in IDLE; accept on `i_req_valid && o_req_ready` at rising edge.
- `i_req_addr` in 32: byte address.
- `i_req_wdata` in 32: store data, LSB-first byte order.
- `i_req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `i_req_signed` in 1: 1 = sign-extend load, 0 = zero-extend.
- `i_req_wren` in 1: 1 store, 0 load.
- `o_rsp_valid` out 1: one-cycle completion pulse.
- `o_rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `o_rsp_err` out 1: valid with `o_rsp_valid`; illegal size, or misaligned with split disabled.
- `o_lsu_addr` out 32, `o_st_data` out 32, `o_lsu_size` out 2, `o_lsu_signed` out 1, `o_lsu_wren` out 1: registered drive to `lsu`.
- `i_ld_data` in 32: `lsu` load data, valid the cycle after address is presented.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: drive beat k, k = 0..n-1.
  - CAPT: loads only; capture the last beat.
  - RESP: pulse `o_rsp_valid`, then return to IDLE.
- Aligned means: byte, half with addr[0]=0, or word with addr[1:0]=0. Aligned gives n=1 at native size. `lsu` performs the extension: `o_lsu_signed` = `i_req_signed`.
- Misaligned gives n=2 (half) or n=4 (word). Beat k uses addr+k (mod 2^32, 0xFFFFFFFF+1 = 0), size 00, `o_lsu_signed`=0, and `o_st_data`[7:0] = wdata byte k.
- Store beats: `o_lsu_wren`=1 every ISSUE cycle; the write commits at that cycle's edge.
- Load beats: `o_lsu_wren`=0. `i_ld_data`[7:0] in the cycle after beat k goes to assembly byte k. Beats pipeline: beat k+1 is issued while beat k is captured.
- Misaligned load result is extended per size/signed by `lsu_ld_extend`. Aligned load result is `i_ld_data` passed through.
- Illegal size: no `lsu` access; go straight to RESP with err=1, rdata=0.
- Outside ISSUE: `o_lsu_wren`=0, and the other `lsu` outputs hold their last value.
- Reset mid-operation: abort, state to IDLE, no response. Bytes already written stay written.

## Timing
- Accept edge is cycle 0.
- ISSUE occupies cycles 1..n.
- Store: RESP in cycle n+1 (aligned SW: pulse in cycle 2).
- Load: CAPT in cycle n+1, RESP in cycle n+2 (aligned LW: cycle 3; misaligned LW: cycle 6).
- Error: RESP in cycle 1.
- `o_req_ready` reasserts in the cycle after RESP, so back-to-back requests have a 1-cycle gap minimum.
- Request inputs are sampled only at the accept edge; they may change afterward.
- Reset values:
  - state IDLE, so `o_req_ready`=1 after release.
  - `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0.
  - `o_lsu_addr`=0, `o_st_data`=0, `o_lsu_size`=0, `o_lsu_signed`=0, `o_lsu_wren`=0.

## Configuration
- `LSU_ALIGN_SPLIT_EN` defined: misaligned half/word requests are split as above.
- `LSU_ALIGN_SPLIT_EN` undefined: misaligned half/word requests make no `lsu` access and give RESP in cycle 1 with err=1, rdata=0. Aligned and illegal-size behaviour is unchanged.

## Structure
- `lsu_align_pkg`:
  - size constants `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
  - state enum `IDLE`/`ISSUE`/`CAPT`/`RESP`.
  - beat-count function from size.
- Sub-module `lsu_ld_extend`: combinational; 32-bit assembly, size and signed in, 32-bit extended result out.

## Test plan
- SW 0x00000010 = 0xCAFEF00D: one wren cycle with size 10, rsp in cycle 2. Then LW 0x10: rdata 0xCAFEF00D, rsp in cycle 3, err=0.
- SW 0x00000065 = 0x11223344 (split on): four byte stores 0x65←44, 0x66←33, 0x67←22, 0x68←11 in cycles 1–4. Then LW 0x65: rdata 0x11223344, rsp in cycle 6.
- SH 0x79 = 0x80F0, then LH 0x79 signed: 0xFFFF80F0. LHU 0x79: 0x000080F0. LB 0x7A signed: 0xFFFFFF80.
- SH 0xFFFFFFFF = 0xABCD: byte 0xCD at 0xFFFFFFFF, byte 0xAB at 0x00000000. LHU back: 0x0000ABCD.
- Size 11 request: rsp cycle 1, err=1, rdata 0, `o_lsu_wren` never high. With `LSU_ALIGN_SPLIT_EN` undefined, LW 0x65: same error response, no access.
- Reset asserted in cycle 2 of the misaligned SW 0x65: `o_lsu_wren`=0 from the next cycle, no `o_rsp_valid`, ready=1 after release. Reading back 0x65 shows 0x44, and 0x66 shows 0x33 if reset hit after beat 1's edge.
